// File: rtl/seq_det_ctrl_pkg.sv
// Shared types and reset-default configuration for the sequence detector controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Unconfigured block behaves as the legacy overlapping 1010 detector
    localparam logic [31:0] DEF_PATTERN = 32'b1010;
    localparam int          DEF_LEN     = 4;
    localparam logic        DEF_OVERLAP = 1'b1;
    localparam int          DEF_TARGET  = 1;

    function automatic int clamp_len(input int len, input int max_len);
        if (len < 1) return 1;
        if (len > max_len) return max_len;
        return len;
    endfunction

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Config, run-control, serial data and status bundle for seq_det_ctrl.
// Latency: n/a (wires only).
// Backpressure: none; din_valid qualifies din, the detector always accepts.
interface seq_det_ctrl_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W) + 1
);
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;
    logic             start;
    logic             abort;
    logic             din;
    logic             din_valid;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;
    logic             done;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    logic             timeout;
`endif

    modport master (
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        input  timeout,
`endif
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        output start, abort, din, din_valid,
        input  match, match_cnt, busy, done
    );

    modport slave (
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        output timeout,
`endif
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        input  start, abort, din, din_valid,
        output match, match_cnt, busy, done
    );

endinterface

// File: rtl/seq_match_core.sv
// Bit-serial history, fill tracking and length-masked pattern compare.
// Latency: match is combinational in the cycle of the final bit.
// Backpressure: none; shifts only when en is high.
module seq_match_core #(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             clr,
    input  logic             fill_clr,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             match
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W - 1);

    logic [PAT_W-2:0] hist;
    logic [LEN_W-1:0] fill;
    logic [PAT_W-1:0] cand;
    logic [PAT_W-1:0] mask;

    assign cand = {hist, din};

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            if (i < int'(len)) mask[i] = 1'b1;
        end
    end

    // fill counts usable history bits, so a match cannot form from cleared bits
    assign match = en && (fill >= (len - LEN_W'(1))) && (((cand ^ pattern) & mask) == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
        end else if (en) begin
            hist <= cand[PAT_W-2:0];
            if (fill_clr) begin
                fill <= '0;
            end else if (fill != FILL_MAX) begin
                fill <= fill + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for a programmable Mealy sequence detector; SEQ_DET_CTRL_TIMEOUT_EN adds a no-match timeout.
// Latency: match same cycle as final bit; busy/done/match_cnt update on the following edge.
// Backpressure: none; din is consumed whenever din_valid is high in RUN.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W   = 8,
    parameter int CNT_W   = 8,
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    parameter int TIMEOUT = 64,
`endif
    parameter int LEN_W   = $clog2(PAT_W) + 1
) (
    input  logic         clk,
    input  logic         rst,
    seq_det_ctrl_if.slave bus
);

    state_t           state;
    state_t           state_nxt;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic [CNT_W-1:0] tgt_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             match;
    logic             run_en;
    logic             start_go;
    logic             cfg_go;
    logic             fill_clr;
    logic             hit_target;
    logic             to_hit;

    assign run_en     = (state == RUN) && bus.din_valid;
    assign start_go   = (state != RUN) && bus.start && !bus.abort;
    assign cfg_go     = (state != RUN) && bus.cfg_we;
    assign fill_clr   = match && !ovl_q;
    assign hit_target = match && (tgt_q != '0) && ((cnt_q + CNT_W'(1)) == tgt_q);

    seq_match_core #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .en       (run_en),
        .din      (bus.din),
        .clr      (start_go),
        .fill_clr (fill_clr),
        .pattern  (pat_q),
        .len      (len_q),
        .match    (match)
    );

    // Config is frozen while a run is in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q <= PAT_W'(DEF_PATTERN);
            len_q <= LEN_W'(DEF_LEN);
            ovl_q <= DEF_OVERLAP;
            tgt_q <= CNT_W'(DEF_TARGET);
        end else if (cfg_go) begin
            pat_q <= bus.cfg_pattern;
            len_q <= LEN_W'(clamp_len(int'(bus.cfg_len), PAT_W));
            ovl_q <= bus.cfg_overlap;
            tgt_q <= bus.cfg_target;
        end
    end

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] idle_q;
    logic            to_q;

    // A match in the terminal cycle wins over the timeout
    assign to_hit = (state == RUN) && !match && (idle_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_q <= '0;
            to_q   <= 1'b0;
        end else if (start_go) begin
            idle_q <= '0;
            to_q   <= 1'b0;
        end else if (state == RUN) begin
            if (match) begin
                idle_q <= '0;
            end else if (!to_hit) begin
                idle_q <= idle_q + TO_W'(1);
            end
            if (to_hit && !bus.abort) to_q <= 1'b1;
        end
    end

    assign bus.timeout = to_q;
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!bus.abort && bus.start) state_nxt = RUN;
            end
            RUN: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (hit_target || to_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (bus.start) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt == RUN);
            done_q <= (state_nxt == DONE);
        end
    end

    // Count saturates so a long target-0 run never wraps back to zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (start_go) begin
            cnt_q <= '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.match     = match;
    assign bus.match_cnt = cnt_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: defaults, overlap modes, gaps, config freeze, abort, reset, timeout.
module tb_seq_det_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seq_det_ctrl_if #(.PAT_W(8), .CNT_W(8)) bus ();

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    seq_det_ctrl #(.PAT_W(8), .CNT_W(8), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
`else
    seq_det_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic b, input logic d, input logic [7:0] c);
        chk({tag, "_busy"}, 32'(bus.busy), 32'(b));
        chk({tag, "_done"}, 32'(bus.done), 32'(d));
        chk({tag, "_cnt"},  32'(bus.match_cnt), 32'(c));
    endtask

    // One clock: inputs applied at negedge, match sampled before the posedge
    task automatic drive(input logic b, input logic v, input logic ab, input logic em, input string tag);
        @(negedge clk);
        bus.din       = b;
        bus.din_valid = v;
        bus.abort     = ab;
        #1;
        chk(tag, 32'(bus.match), 32'(em));
        @(posedge clk);
        #1;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.abort     = 1'b0;
    endtask

    // Bits and expected match flags given MSB-first (first serial bit is bit n-1)
    task automatic run_bits(input logic [15:0] bits, input logic [15:0] em, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) drive(bits[i], 1'b1, 1'b0, em[i], tag);
    endtask

    task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] t,
                          input logic st);
        @(negedge clk);
        bus.cfg_pattern = p;
        bus.cfg_len     = l;
        bus.cfg_overlap = o;
        bus.cfg_target  = t;
        bus.cfg_we      = 1'b1;
        bus.start       = st;
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
        bus.start  = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
    endtask

    initial begin
        rst             = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_overlap = 1'b0;
        bus.cfg_target  = '0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.din         = 1'b0;
        bus.din_valid   = 1'b0;

        // Reset state; match must stay low outside RUN even with valid data
        repeat (2) @(posedge clk);
        #1;
        bus.din_valid = 1'b1;
        #1;
        chk("reset_match", 32'(bus.match), 32'd0);
        chk_status("reset", 1'b0, 1'b0, 8'd0);
        bus.din_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Default config: 1010, target 1
        do_start();
        chk_status("t1_start", 1'b1, 1'b0, 8'd0);
        run_bits(16'b1010, 16'b0001, 4, "t1_match");
        chk_status("t1_end", 1'b0, 1'b1, 8'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, "t1_done_nomatch");

        // Overlapping, run until abort
        do_cfg(8'b1010, 4'd4, 1'b1, 8'd0, 1'b0);
        do_start();
        chk_status("t2_start", 1'b1, 1'b0, 8'd0);
        run_bits(16'b101010, 16'b000101, 6, "t2_match");
        chk_status("t2_run", 1'b1, 1'b0, 8'd2);
        do_abort();
        chk_status("t2_abort", 1'b0, 1'b0, 8'd2);

        // Non-overlapping
        do_cfg(8'b1010, 4'd4, 1'b0, 8'd0, 1'b0);
        do_start();
        run_bits(16'b10101010, 16'b00010001, 8, "t3_match");
        chk_status("t3_run", 1'b1, 1'b0, 8'd2);
        do_abort();

        // 110, target 2, config written together with start, gaps with din low
        do_cfg(8'b110, 4'd3, 1'b1, 8'd2, 1'b1);
        chk_status("t4_start", 1'b1, 1'b0, 8'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, "t4_b1");
        drive(1'b0, 1'b0, 1'b0, 1'b0, "t4_gap");
        drive(1'b1, 1'b1, 1'b0, 1'b0, "t4_b2");
        drive(1'b0, 1'b0, 1'b0, 1'b0, "t4_gap");
        drive(1'b0, 1'b1, 1'b0, 1'b1, "t4_b3");
        chk_status("t4_mid", 1'b1, 1'b0, 8'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, "t4_gap");
        drive(1'b1, 1'b1, 1'b0, 1'b0, "t4_b4");
        drive(1'b0, 1'b0, 1'b0, 1'b0, "t4_gap");
        drive(1'b1, 1'b1, 1'b0, 1'b0, "t4_b5");
        drive(1'b0, 1'b0, 1'b0, 1'b0, "t4_gap");
        drive(1'b0, 1'b1, 1'b0, 1'b1, "t4_b6");
        chk_status("t4_end", 1'b0, 1'b1, 8'd2);

        // Config write in RUN ignored; abort beats match-to-DONE
        do_cfg(8'b1010, 4'd4, 1'b1, 8'd1, 1'b1);
        do_cfg(8'b11111, 4'd5, 1'b0, 8'd0, 1'b0);
        run_bits(16'b101, 16'b000, 3, "t5_bits");
        drive(1'b0, 1'b1, 1'b1, 1'b1, "t5_abort_match");
        chk_status("t5_end", 1'b0, 1'b0, 8'd1);

        // Length clamping: 0 -> 1, 15 -> 8
        do_cfg(8'h01, 4'd0, 1'b1, 8'd0, 1'b1);
        run_bits(16'b101, 16'b101, 3, "t6_len0");
        chk_status("t6_len0", 1'b1, 1'b0, 8'd2);
        do_abort();
        do_cfg(8'hA5, 4'd15, 1'b1, 8'd1, 1'b1);
        run_bits(16'hA5, 16'h01, 8, "t6_len15");
        chk_status("t6_len15", 1'b0, 1'b1, 8'd1);

        // Asynchronous reset mid-run restores defaults and clears history
        do_cfg(8'b1010, 4'd4, 1'b1, 8'd0, 1'b1);
        run_bits(16'b1010101, 16'b0001010, 7, "t7_pre");
        chk_status("t7_pre", 1'b1, 1'b0, 8'd2);
        @(negedge clk);
        bus.din_valid = 1'b1;
        rst           = 1'b0;
        #1;
        chk("t7_rst_match", 32'(bus.match), 32'd0);
        chk_status("t7_rst", 1'b0, 1'b0, 8'd0);
        bus.din_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_start();
        drive(1'b0, 1'b1, 1'b0, 1'b0, "t7_hist_clr");
        run_bits(16'b1010, 16'b0001, 4, "t7_default");
        chk_status("t7_end", 1'b0, 1'b1, 8'd1);

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        // 8 clocks in RUN without a match
        do_start();
        chk("t8_to_start", 32'(bus.timeout), 32'd0);
        repeat (7) @(posedge clk);
        #1;
        chk_status("t8_before", 1'b1, 1'b0, 8'd0);
        chk("t8_to_before", 32'(bus.timeout), 32'd0);
        @(posedge clk);
        #1;
        chk_status("t8_after", 1'b0, 1'b1, 8'd0);
        chk("t8_to_after", 32'(bus.timeout), 32'd1);
        do_start();
        chk("t8_to_clr", 32'(bus.timeout), 32'd0);
        do_abort();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Run controller for a programmable bit-serial Mealy sequence detector.
- Holds the pattern configuration, arms and disarms detection, and counts matches.
- Stops after a programmed number of matches and flags completion.
- Sits between the register/config interface and the serial data stream.
- Reset configuration detects 1010 with overlap, so an unconfigured block behaves as the existing 1010 detector.

Parameters:
PAT_W, 8, maximum pattern length in bits
CNT_W, 8, match counter / target width
LEN_W, $clog2(PAT_W)+1, width of cfg_len (derived; do not override)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous, active-low reset
cfg_we  in  1  config write strobe
cfg_pattern  in  PAT_W  pattern; bit [len-1] is the first serial bit, bit 0 the last
cfg_len  in  LEN_W  pattern length
cfg_overlap  in  1  1 = overlapping matches allowed
cfg_target  in  CNT_W  matches before DONE; 0 = run until abort
start  in  1  arm detection
abort  in  1  stop detection
din  in  1  serial data bit
din_valid  in  1  din qualifier
match  out  1  Mealy match pulse (combinational)
match_cnt  out  CNT_W  matches in current/last run
busy  out  1  state == RUN
done  out  1  state == DONE

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE; history and fill cleared; match_cnt 0.
  - Config registers load defaults: pattern 'b1010, len 4, overlap 1, target 1.
  - Outputs: match 0, busy 0, done 0.
- States IDLE, RUN, DONE. busy and done are registered decodes of state.
- Config:
  - cfg_we is sampled only in IDLE or DONE; it is ignored in RUN.
  - cfg_len 0 is stored as 1; cfg_len > PAT_W is stored as PAT_W.
- IDLE/DONE + start:
  - Next state RUN.
  - Clears history, fill counter, match_cnt and done.
  - If start and cfg_we are high together, the config write applies and the run uses the new config.
- RUN, din_valid=1:
  - cand = {hist, din}.
  - match = (fill >= len-1) && (cand[len-1:0] == pattern[len-1:0]).
  - match is asserted in the same cycle as the final bit, with zero latency.
  - match is 0 whenever state != RUN or din_valid=0.
- Each valid bit (posedge):
  - hist shifts in din.
  - fill increments, saturating at PAT_W-1.
- On match:
  - match_cnt increments, saturating at all-ones.
  - If overlap=0, fill is reset to 0 so the bits of the match are not reused; hist still shifts.
- Completion: if target != 0 and the match makes match_cnt+1 == target, next state is DONE. match_cnt holds.
- din_valid=0 in RUN: no shift and no count change.
- abort in RUN:
  - Next state IDLE; match_cnt holds; done 0.
  - abort has priority over a same-cycle match-to-DONE transition (the count still increments) and over start.
- start in RUN is ignored. abort in IDLE/DONE: DONE goes to IDLE, IDLE stays IDLE.
- rst low mid-run returns immediately to reset values, including default config.

Optional Feature:
SEQ_DET_CTRL_TIMEOUT_EN
- Defined:
  - Adds parameter TIMEOUT (default 64) and output timeout (1 bit, reset 0).
  - An idle counter counts clocks in RUN since the last match (or since start) and is cleared on each match.
  - When it reaches TIMEOUT-1 without a match, next state is DONE and timeout=1.
  - timeout clears on start or rst.
  - A match in the terminal cycle takes priority, and timeout stays 0.
- Undefined: no counter, no port. A run ends only by target or abort.

Decomposition:
- Package seq_det_pkg:
  - state_t enum {IDLE, RUN, DONE}
  - DEF_PATTERN = 'b1010, DEF_LEN = 4, DEF_OVERLAP = 1, DEF_TARGET = 1
- Sub-module seq_match_core:
  - History shift register, fill counter, length-masked compare, and the combinational match.
  - Inputs: en, din, clr, fill_clr, pattern, len.
- seq_det_ctrl holds config, FSM, match counter and the optional timeout.

Test Plan:
- Defaults; start; valid stream 1,0,1,0 → match high on the 4th bit only; done next cycle; match_cnt=1.
- target=0, overlap=1, stream 1,0,1,0,1,0 → match on bits 4 and 6; match_cnt=2; busy stays 1.
- overlap=0, target=0, same stream then 1,0 → match on bits 4 and 8 only; match_cnt=2.
- pattern 'b110, len 3, target 2; stream 1,1,0 with din_valid low between bits, then 1,1,0 → no match during gaps; DONE after bit 6; match_cnt=2.
- cfg_we with len 5 during RUN → ignored (1010 still detected). Then abort with a simultaneous final 0 of 1010 → state IDLE, match_cnt incremented, done 0.
- rst low mid-run after bits 1,0,1 → all outputs 0; after release, start then a single 0 → no match (history cleared). With SEQ_DET_CTRL_TIMEOUT_EN and TIMEOUT=8: 8 clocks in RUN with no match → timeout=1, done=1.
